instr_packer: RTL and testbench
===============================

# instr_packer

Builds 32-bit RV32I instruction words from separate opcode, register, funct and immediate fields, and writes them sequentially into instruction memory. It is the inverse of the core's immediate-extension path: it scatters a full 32-bit immediate into the I/S/B/U/J bit positions and checks that the immediate is encodable. It sits between the test/program-loader front end and the instruction memory write port of the multi-cycle RISC-V core. It has a one-deep registered output with memory backpressure.

## Interface
- ADDR_W, 32, width of the write address
- BASE_ADDR, 0, address of the first word written after reset
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  field set is presented
- in_ready  output  1  block accepts the field set this cycle
- imm_sel  input  3  0=I, 1=S, 2=J, 3=U, 4=B, 5=R; 6 and 7 are invalid
- imm  input  32  full signed immediate, byte offset for B/J
- opcode  input  7  inst[6:0]
- rd, rs1, rs2  input  5 each  register fields
- funct3  input  3  inst[14:12]
- funct7  input  7  inst[31:25], R only
- wr_en  output  1  pending word valid
- wr_addr  output  ADDR_W  address of pending word
- wr_data  output  32  pending instruction word
- mem_ready  input  1  memory takes the word when wr_en is high
- err  output  1  sticky encoding-error flag
- err_cnt  output  8  rejected field sets, saturates at 255
- wr_count  output  16  words written, wraps

## Operation
- Packing per type (unused fields ignored):
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - U: {imm[31:12], rd, opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
- Encodability check, evaluated on acceptance:
  - I/S: imm[31:11] all equal.
  - B: imm[0]=0 and imm[31:12] all equal.
  - J: imm[0]=0 and imm[31:20] all equal.
  - U: imm[11:0]=0.
  - R: always passes.
  - imm_sel 6/7: always fails.
- Accepted and valid: load the output register and assert wr_en.
- Accepted and invalid:
  - Set err and increment err_cnt (saturating).
  - Do not assert wr_en, do not change wr_addr or wr_count.
  - If an earlier word is still pending, it is unaffected.
- Completion when wr_en && mem_ready:
  - wr_addr increments by 4, modulo 2^ADDR_W.
  - wr_count increments by 1.
- Output hold: wr_data and wr_addr stay stable while wr_en && !mem_ready.

## Timing
- in_ready = !wr_en || mem_ready. This is combinational; there is no combinational path from in_valid.
- Acceptance happens at the edge where in_valid && in_ready.
- Latency: wr_en is high in the cycle after acceptance.
- Throughput: one word per cycle while mem_ready=1.
- Back-to-back case: completion and a new acceptance at the same edge means wr_en stays high with the new word. Its address is the old address + 4.
- Reset values: wr_en=0, wr_data=0, wr_addr=BASE_ADDR, err=0, err_cnt=0, wr_count=0. in_ready is therefore 1.
- Reset mid-operation:
  - A pending word is dropped and never written.
  - A field set presented in the reset cycle is not accepted.
- err clears only on rst.

## Test plan
- Single write: I, opcode=0x13, rd=1, rs1=0, funct3=0, imm=5, mem_ready=1 -> next cycle wr_en=1, wr_data=0x00500093, wr_addr=0. The cycle after, wr_addr=4 and wr_count=1.
- Stream of four words, mem_ready=1:
  - S: opcode 0x23, f3=2, rs1=1, rs2=2, imm=8 -> 0x0020A423.
  - B: opcode 0x63, f3=0, rs1=0, rs2=0, imm=-4 -> 0xFE000EE3.
  - J: opcode 0x6F, rd=1, imm=8 -> 0x008000EF.
  - U: opcode 0x37, rd=5, imm=0x12345000 -> 0x123452B7.
  - Required: addresses 0, 4, 8, 12 on consecutive cycles; in_ready high throughout.
- Backpressure: hold mem_ready=0 for 3 cycles with a word pending -> in_ready=0, wr_data and wr_addr constant. Release -> the word completes, then the next queued input is accepted at that same edge.
- Errors -> each sets err, err_cnt=1,2,3,4, and no wr_en:
  - I with imm=2048
  - B with imm=3
  - U with imm=0x1001
  - imm_sel=6
- Error saturation and reset: 300 invalid inputs -> err_cnt=255. Then assert rst with a word pending -> wr_en=0, wr_addr=BASE_ADDR, err=0, err_cnt=0, and no write ever issued for the dropped word.
- Address wrap: ADDR_W=4, BASE_ADDR=12, two valid words -> addresses 12 then 0.

Source files
------------

// File: rtl/instr_packer.sv
// Packs RV32I instruction fields into 32-bit words and streams them to the
// instruction memory write port through a one-deep registered output stage.
module instr_packer #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        imm_sel,
    input  logic [31:0]       imm,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    input  logic              mem_ready,
    output logic              err,
    output logic [7:0]        err_cnt,
    output logic [15:0]       wr_count
);

    localparam logic [2:0] SelI = 3'd0;
    localparam logic [2:0] SelS = 3'd1;
    localparam logic [2:0] SelJ = 3'd2;
    localparam logic [2:0] SelU = 3'd3;
    localparam logic [2:0] SelB = 3'd4;
    localparam logic [2:0] SelR = 3'd5;

    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              err_q, err_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic [15:0]       wr_count_q, wr_count_d;

    logic [31:0] packed_word;
    logic        encodable;
    logic        accept;
    logic        complete;

    // Sign-extension checks: the dropped upper bits must all match the top kept bit.
    logic sext11_ok, sext12_ok, sext20_ok;
    assign sext11_ok = (imm[31:11] == '0) || (imm[31:11] == '1);
    assign sext12_ok = (imm[31:12] == '0) || (imm[31:12] == '1);
    assign sext20_ok = (imm[31:20] == '0) || (imm[31:20] == '1);

    // Scatter fields into the instruction word and judge encodability.
    always_comb begin
        packed_word = '0;
        encodable   = 1'b0;
        case (imm_sel)
            SelI: begin
                packed_word = {imm[11:0], rs1, funct3, rd, opcode};
                encodable   = sext11_ok;
            end
            SelS: begin
                packed_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                encodable   = sext11_ok;
            end
            SelB: begin
                packed_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                encodable   = !imm[0] && sext12_ok;
            end
            SelU: begin
                packed_word = {imm[31:12], rd, opcode};
                encodable   = (imm[11:0] == 12'd0);
            end
            SelJ: begin
                packed_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                encodable   = !imm[0] && sext20_ok;
            end
            SelR: begin
                packed_word = {funct7, rs2, rs1, funct3, rd, opcode};
                encodable   = 1'b1;
            end
            default: begin
                packed_word = '0;
                encodable   = 1'b0;
            end
        endcase
    end

    assign in_ready = !wr_en_q || mem_ready;
    assign accept   = in_valid && in_ready;
    assign complete = wr_en_q && mem_ready;

    // Next-state: completion advances address/count; accepted words reload the
    // output stage, rejected ones only touch the error bookkeeping.
    always_comb begin
        wr_en_d    = wr_en_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        err_d      = err_q;
        err_cnt_d  = err_cnt_q;
        wr_count_d = wr_count_q;

        if (complete) begin
            wr_en_d    = 1'b0;
            wr_addr_d  = wr_addr_q + ADDR_W'(4);
            wr_count_d = wr_count_q + 16'd1;
        end

        if (accept) begin
            if (encodable) begin
                wr_en_d   = 1'b1;
                wr_data_d = packed_word;
            end else begin
                err_d = 1'b1;
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
            end
        end
    end

    // State registers with synchronous reset; reset drops any pending word.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q    <= 1'b0;
            wr_addr_q  <= BASE_ADDR;
            wr_data_q  <= '0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            wr_count_q <= '0;
        end else begin
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign err      = err_q;
    assign err_cnt  = err_cnt_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_instr_packer.sv
// Scoreboard bench for instr_packer: two instances (32-bit address at 0, and a
// 4-bit address starting at 12 to exercise wrap) share one stimulus stream.
module tb_instr_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready, in_ready_w;
    logic [2:0]  imm_sel;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        mem_ready;

    logic        wr_en, wr_en_w;
    logic [31:0] wr_addr;
    logic [3:0]  wr_addr_w;
    logic [31:0] wr_data, wr_data_w;
    logic        err, err_w;
    logic [7:0]  err_cnt, err_cnt_w;
    logic [15:0] wr_count, wr_count_w;

    int total = 0;
    int bad   = 0;
    int n_issued = 0;
    int waited;
    int wait_b;

    logic [63:0] q[$];
    logic [63:0] qw[$];

    always #5 clk = ~clk;

    instr_packer #(.ADDR_W(32), .BASE_ADDR(32'd0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .imm_sel(imm_sel), .imm(imm), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .mem_ready(mem_ready), .err(err), .err_cnt(err_cnt),
        .wr_count(wr_count)
    );

    instr_packer #(.ADDR_W(4), .BASE_ADDR(4'd12)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
        .imm_sel(imm_sel), .imm(imm), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .wr_en(wr_en_w), .wr_addr(wr_addr_w),
        .wr_data(wr_data_w), .mem_ready(mem_ready), .err(err_w), .err_cnt(err_cnt_w),
        .wr_count(wr_count_w)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: a word is written at an edge where wr_en && mem_ready outside reset.
    always @(negedge clk) begin
        if (!rst && wr_en === 1'b1 && mem_ready) begin
            if (q.size() == 0) begin
                check("unexpected_write", {32'd0, wr_data}, 64'hDEAD);
            end else begin
                check("write_word", {wr_addr, wr_data}, q.pop_front());
            end
        end
        if (!rst && wr_en_w === 1'b1 && mem_ready) begin
            if (qw.size() == 0) begin
                check("unexpected_write_w", {32'd0, wr_data_w}, 64'hDEAD);
            end else begin
                check("write_word_w", {28'd0, wr_addr_w, wr_data_w}, qw.pop_front());
            end
        end
    end

    // Present one field set, wait (bounded) for acceptance, queue its expected word.
    task automatic send(input logic [2:0] sel, input logic [31:0] im, input logic [6:0] op,
                        input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [2:0] f3, input logic [6:0] f7,
                        input logic ok, input logic [31:0] exp, output int nwait);
        logic [3:0] aw;
        imm_sel = sel; imm = im; opcode = op; rd = d; rs1 = s1; rs2 = s2;
        funct3 = f3; funct7 = f7; in_valid = 1'b1;
        nwait = 0;
        @(negedge clk);
        while (!in_ready && nwait < 50) begin
            nwait++;
            @(negedge clk);
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout: got in_ready=0 want 1");
        end else if (ok) begin
            aw = 4'd12 + 4'(4 * n_issued);
            q.push_back({32'(4 * n_issued), exp});
            qw.push_back({28'd0, aw, exp});
            n_issued++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with a valid field set presented: it must not be accepted.
        rst = 1'b1; mem_ready = 1'b1; in_valid = 1'b1;
        imm_sel = 3'd0; imm = 32'd5; opcode = 7'h13; rd = 5'd1; rs1 = 5'd0; rs2 = 5'd0;
        funct3 = 3'd0; funct7 = 7'd0;
        idle(2);
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("rst_wr_en", {63'd0, wr_en}, 64'd0);
        check("rst_wr_data", {32'd0, wr_data}, 64'd0);
        check("rst_wr_addr", {32'd0, wr_addr}, 64'd0);
        check("rst_wr_addr_w", {60'd0, wr_addr_w}, 64'd12);
        check("rst_err", {63'd0, err}, 64'd0);
        check("rst_err_cnt", {56'd0, err_cnt}, 64'd0);
        check("rst_wr_count", {48'd0, wr_count}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Single I-type write.
        @(posedge clk); #1;
        send(3'd0, 32'd5, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 1'b1, 32'h00500093, waited);
        @(negedge clk);
        check("single_wr_en", {63'd0, wr_en}, 64'd1);
        check("single_wr_data", {32'd0, wr_data}, 64'h00500093);
        check("single_wr_addr", {32'd0, wr_addr}, 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("single_addr_after", {32'd0, wr_addr}, 64'd4);
        check("single_count_after", {48'd0, wr_count}, 64'd1);
        check("wrap_addr_w", {60'd0, wr_addr_w}, 64'd0);

        // Fresh reset, then a back-to-back stream of four words at 0,4,8,12.
        @(posedge clk); #1;
        rst = 1'b1; q.delete(); qw.delete(); n_issued = 0;
        idle(1);
        rst = 1'b0;
        send(3'd1, 32'd8, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 1'b1, 32'h0020A423, waited);
        check("stream_ready_s", 64'(waited), 64'd0);
        send(3'd4, 32'hFFFFFFFC, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 1'b1, 32'hFE000EE3,
             waited);
        check("stream_ready_b", 64'(waited), 64'd0);
        send(3'd2, 32'd8, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 1'b1, 32'h008000EF, waited);
        check("stream_ready_j", 64'(waited), 64'd0);
        send(3'd3, 32'h12345000, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 1'b1, 32'h123452B7,
             waited);
        check("stream_ready_u", 64'(waited), 64'd0);
        idle(2);
        check("stream_count", {48'd0, wr_count}, 64'd4);

        // Backpressure: sub x5,x6,x7 held for 3 cycles while add x3,x1,x2 waits.
        mem_ready = 1'b0;
        send(3'd5, 32'd0, 7'h33, 5'd5, 5'd6, 5'd7, 3'd0, 7'h20, 1'b1, 32'h407302B3, waited);
        fork
            send(3'd5, 32'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 1'b1, 32'h002081B3,
                 wait_b);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("bp_in_ready", {63'd0, in_ready}, 64'd0);
                    check("bp_wr_data", {32'd0, wr_data}, 64'h407302B3);
                    check("bp_wr_addr", {32'd0, wr_addr}, 64'd16);
                end
                @(posedge clk); #1;
                mem_ready = 1'b1;
            end
        join
        check("bp_same_edge_accept", 64'(wait_b), 64'd3);
        @(negedge clk);
        check("bp_next_wr_en", {63'd0, wr_en}, 64'd1);
        check("bp_next_data", {32'd0, wr_data}, 64'h002081B3);
        check("bp_next_addr", {32'd0, wr_addr}, 64'd20);
        idle(2);
        check("bp_count", {48'd0, wr_count}, 64'd6);

        // Encoding errors.
        send(3'd0, 32'd2048, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 1'b0, 32'd0, waited);
        @(negedge clk);
        check("err_i_flag", {63'd0, err}, 64'd1);
        check("err_i_cnt", {56'd0, err_cnt}, 64'd1);
        check("err_i_wr_en", {63'd0, wr_en}, 64'd0);
        @(posedge clk); #1;
        send(3'd4, 32'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 1'b0, 32'd0, waited);
        @(negedge clk);
        check("err_b_cnt", {56'd0, err_cnt}, 64'd2);
        check("err_b_wr_en", {63'd0, wr_en}, 64'd0);
        @(posedge clk); #1;
        send(3'd3, 32'h1001, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 1'b0, 32'd0, waited);
        @(negedge clk);
        check("err_u_cnt", {56'd0, err_cnt}, 64'd3);
        check("err_u_wr_en", {63'd0, wr_en}, 64'd0);
        @(posedge clk); #1;
        send(3'd6, 32'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 1'b0, 32'd0, waited);
        @(negedge clk);
        check("err_sel6_cnt", {56'd0, err_cnt}, 64'd4);
        check("err_sel6_wr_en", {63'd0, wr_en}, 64'd0);
        check("err_addr_hold", {32'd0, wr_addr}, 64'd24);
        check("err_count_hold", {48'd0, wr_count}, 64'd6);

        // Boundary: imm=-2048 is the most negative encodable I immediate.
        @(posedge clk); #1;
        send(3'd0, 32'hFFFFF800, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 1'b1, 32'h80000093,
             waited);
        idle(2);
        check("min_i_count", {48'd0, wr_count}, 64'd7);
        check("err_sticky", {63'd0, err}, 64'd1);

        // Saturation.
        for (int i = 0; i < 300; i++) begin
            send(3'd7, 32'd0, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 1'b0, 32'd0, waited);
        end
        @(negedge clk);
        check("err_cnt_sat", {56'd0, err_cnt}, 64'd255);

        // Reset with a word pending: it must be dropped, never written.
        @(posedge clk); #1;
        mem_ready = 1'b0;
        send(3'd2, 32'd8, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 1'b1, 32'h008000EF, waited);
        rst = 1'b1; q.delete(); qw.delete(); n_issued = 0;
        idle(1);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_wr_en", {63'd0, wr_en}, 64'd0);
        check("midrst_wr_addr", {32'd0, wr_addr}, 64'd0);
        check("midrst_err", {63'd0, err}, 64'd0);
        check("midrst_err_cnt", {56'd0, err_cnt}, 64'd0);
        check("midrst_wr_data", {32'd0, wr_data}, 64'd0);
        @(posedge clk); #1;
        mem_ready = 1'b1;
        idle(3);
        check("midrst_count", {48'd0, wr_count}, 64'd0);

        // Writes restart at the base address after reset.
        send(3'd0, 32'd5, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 1'b1, 32'h00500093, waited);
        idle(3);
        check("post_rst_count", {48'd0, wr_count}, 64'd1);
        check("queue_drained", 64'(q.size()), 64'd0);
        check("queue_w_drained", 64'(qw.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
